// File: rtl/relu_vector_streamer_if.sv
// Handshake bundle between the ReLU layer, the vector streamer and the next layer.
// The slave modport is the streamer's view; master is the surrounding environment.
interface relu_vector_streamer_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64
);
    localparam int IW = $clog2(SIZE);

    logic                        in_valid;
    logic                        in_ready;
    logic [SIZE-1:0][WIDTH-1:0]  input_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_data;
    logic [IW-1:0]               out_index;
    logic                        out_last;

    modport slave (
        input  in_valid,
        input  input_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_index,
        output out_last
    );

    modport master (
        output in_valid,
        output input_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/relu_vector_streamer.sv
// Captures a whole activation vector in one handshake and replays it one element
// per beat, optionally skipping zero elements while always emitting the last one.
module relu_vector_streamer #(
    parameter int WIDTH      = 16,
    parameter int NFRAC      = 10,
    parameter int SIZE       = 64,
    parameter int SKIP_ZEROS = 0
) (
    input  logic clk,
    input  logic rst,
    relu_vector_streamer_if.slave bus
);
    localparam int            IW       = $clog2(SIZE);
    localparam logic [IW-1:0] LAST_PTR = IW'(SIZE - 1);

    if (NFRAC > WIDTH) begin : g_nfrac_check
        $error("NFRAC must not exceed WIDTH");
    end

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [IW-1:0]              ptr;
    logic [IW-1:0]              ptr_next;
    logic [SIZE-1:0][WIDTH-1:0] data_buf;
    logic [SIZE-1:0]            nz_mask;
    logic [SIZE-1:0]            in_mask;
    logic                       capture;

    // Smallest index q >= start whose element is non-zero; falls back to the last index.
    function automatic logic [IW-1:0] next_nz(input logic [SIZE-1:0] mask, input int start);
        next_nz = LAST_PTR;
        for (int q = SIZE - 2; q >= 0; q--) begin
            if (q >= start && mask[q]) begin
                next_nz = q[IW-1:0];
            end
        end
    endfunction

    always_comb begin
        in_mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            in_mask[i] = (bus.input_data[i] != '0);
        end
    end

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        capture       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = data_buf[ptr];
        bus.out_index = ptr;
        case (state)
            IDLE: begin
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                    ptr_next   = (SKIP_ZEROS != 0) ? next_nz(in_mask, 0) : '0;
                end
            end
            STREAM: begin
                bus.out_valid = 1'b1;
                bus.out_last  = (ptr == LAST_PTR);
                if (bus.out_ready) begin
                    if (ptr == LAST_PTR) begin
                        state_next = IDLE;
                        ptr_next   = '0;
                    end else begin
                        ptr_next = (SKIP_ZEROS != 0) ? next_nz(nz_mask, int'(ptr) + 1)
                                                     : ptr + IW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // The buffer and its non-zero mask only change on a capture, so they stay frozen while streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            data_buf <= '0;
            nz_mask  <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (capture) begin
                data_buf <= bus.input_data;
                nz_mask  <= in_mask;
            end
        end
    end
endmodule

// File: tb/tb_relu_vector_streamer.sv
// Directed bench for relu_vector_streamer: one instance streams every element,
// a second one skips zero elements; both share clock and reset.
module tb_relu_vector_streamer;
    localparam int WIDTH = 16;
    localparam int SIZE  = 4;

    logic clk;
    logic rst;
    int   n_vectors;
    int   n_miscompares;

    relu_vector_streamer_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus0 ();
    relu_vector_streamer_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus1 ();

    relu_vector_streamer #(.WIDTH(WIDTH), .NFRAC(10), .SIZE(SIZE), .SKIP_ZEROS(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    relu_vector_streamer #(.WIDTH(WIDTH), .NFRAC(10), .SIZE(SIZE), .SKIP_ZEROS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic logic [SIZE-1:0][WIDTH-1:0] pack4(input logic [15:0] e0, e1, e2, e3);
        logic [SIZE-1:0][WIDTH-1:0] v;
        v[0] = e0;
        v[1] = e1;
        v[2] = e2;
        v[3] = e3;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBeat(input logic sel, input string tag, input logic [1:0] idx,
                             input logic [15:0] data, input logic last);
        if (sel) begin
            checkOutput({tag, ".valid"}, 32'(bus1.out_valid), 32'd1);
            checkOutput({tag, ".index"}, 32'(bus1.out_index), 32'(idx));
            checkOutput({tag, ".data"},  32'(bus1.out_data),  32'(data));
            checkOutput({tag, ".last"},  32'(bus1.out_last),  32'(last));
        end else begin
            checkOutput({tag, ".valid"}, 32'(bus0.out_valid), 32'd1);
            checkOutput({tag, ".index"}, 32'(bus0.out_index), 32'(idx));
            checkOutput({tag, ".data"},  32'(bus0.out_data),  32'(data));
            checkOutput({tag, ".last"},  32'(bus0.out_last),  32'(last));
        end
    endtask

    task automatic checkIdle(input logic sel, input string tag);
        if (sel) begin
            checkOutput({tag, ".valid"}, 32'(bus1.out_valid), 32'd0);
            checkOutput({tag, ".ready"}, 32'(bus1.in_ready),  32'd1);
        end else begin
            checkOutput({tag, ".valid"}, 32'(bus0.out_valid), 32'd0);
            checkOutput({tag, ".ready"}, 32'(bus0.in_ready),  32'd1);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [SIZE-1:0][WIDTH-1:0] vec);
        if (sel) begin
            checkOutput("capture.ready1", 32'(bus1.in_ready), 32'd1);
            bus1.input_data = vec;
            bus1.in_valid   = 1'b1;
            tick();
            bus1.in_valid   = 1'b0;
        end else begin
            checkOutput("capture.ready0", 32'(bus0.in_ready), 32'd1);
            bus0.input_data = vec;
            bus0.in_valid   = 1'b1;
            tick();
            bus0.in_valid   = 1'b0;
        end
    endtask

    initial begin
        logic [SIZE-1:0][WIDTH-1:0] vec_a;
        logic [SIZE-1:0][WIDTH-1:0] vec_n;

        n_vectors       = 0;
        n_miscompares   = 0;
        rst             = 1'b1;
        bus0.in_valid   = 1'b0;
        bus0.input_data = '0;
        bus0.out_ready  = 1'b1;
        bus1.in_valid   = 1'b0;
        bus1.input_data = '0;
        bus1.out_ready  = 1'b1;
        vec_a = pack4(16'h0400, 16'h0000, 16'h0C00, 16'h0001);

        // reset state
        tick();
        checkOutput("rst.in_ready",  32'(bus0.in_ready),  32'd0);
        checkOutput("rst.out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("rst.out_last",  32'(bus0.out_last),  32'd0);
        checkOutput("rst.out_data",  32'(bus0.out_data),  32'd0);
        checkOutput("rst.out_index", 32'(bus0.out_index), 32'd0);
        rst = 1'b0;
        #1;
        checkIdle(1'b0, "rst.release0");
        checkIdle(1'b1, "rst.release1");

        // test 1: full-rate stream, no skipping
        applyStimulus(1'b0, vec_a);
        checkBeat(1'b0, "t1.b0", 2'd0, 16'h0400, 1'b0);
        tick();
        checkBeat(1'b0, "t1.b1", 2'd1, 16'h0000, 1'b0);
        tick();
        checkBeat(1'b0, "t1.b2", 2'd2, 16'h0C00, 1'b0);
        tick();
        checkBeat(1'b0, "t1.b3", 2'd3, 16'h0001, 1'b1);
        tick();
        checkIdle(1'b0, "t1.idle");

        // test 2: backpressure while index 1 is presented
        applyStimulus(1'b0, vec_a);
        checkBeat(1'b0, "t2.b0", 2'd0, 16'h0400, 1'b0);
        tick();
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkBeat(1'b0, "t2.hold", 2'd1, 16'h0000, 1'b0);
            tick();
        end
        checkBeat(1'b0, "t2.b1", 2'd1, 16'h0000, 1'b0);
        bus0.out_ready = 1'b1;
        tick();
        checkBeat(1'b0, "t2.b2", 2'd2, 16'h0C00, 1'b0);
        tick();
        checkBeat(1'b0, "t2.b3", 2'd3, 16'h0001, 1'b1);
        tick();
        checkIdle(1'b0, "t2.idle");

        // test 3: sparse vector with zero skipping
        applyStimulus(1'b1, pack4(16'h0000, 16'h0200, 16'h0000, 16'h0000));
        checkBeat(1'b1, "t3.b1", 2'd1, 16'h0200, 1'b0);
        tick();
        checkBeat(1'b1, "t3.b3", 2'd3, 16'h0000, 1'b1);
        tick();
        checkIdle(1'b1, "t3.idle");

        // test 4: all-zero vector yields only the final element
        applyStimulus(1'b1, pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000));
        checkBeat(1'b1, "t4.b3", 2'd3, 16'h0000, 1'b1);
        tick();
        checkIdle(1'b1, "t4.idle");

        // test 7: skipping with a non-zero first element and a negative value
        applyStimulus(1'b1, pack4(16'h0005, 16'h0000, 16'hFFF0, 16'h0007));
        checkBeat(1'b1, "t7.b0", 2'd0, 16'h0005, 1'b0);
        tick();
        checkBeat(1'b1, "t7.b2", 2'd2, 16'hFFF0, 1'b0);
        tick();
        checkBeat(1'b1, "t7.b3", 2'd3, 16'h0007, 1'b1);
        tick();
        checkIdle(1'b1, "t7.idle");

        // test 5: reset in the middle of a stream
        applyStimulus(1'b0, vec_a);
        tick();
        tick();
        checkBeat(1'b0, "t5.b2", 2'd2, 16'h0C00, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("t5.rst.out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("t5.rst.out_last",  32'(bus0.out_last),  32'd0);
        checkOutput("t5.rst.in_ready",  32'(bus0.in_ready),  32'd0);
        checkOutput("t5.rst.out_data",  32'(bus0.out_data),  32'd0);
        checkOutput("t5.rst.out_index", 32'(bus0.out_index), 32'd0);
        tick();
        checkOutput("t5.rst.held_valid", 32'(bus0.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        checkIdle(1'b0, "t5.release");
        applyStimulus(1'b0, pack4(16'd1, 16'd2, 16'd3, 16'd4));
        for (int i = 0; i < 4; i++) begin
            checkBeat(1'b0, "t5.new", 2'(i), 16'(i + 1), (i == 3));
            tick();
        end
        checkIdle(1'b0, "t5.idle");

        // test 6: input activity during a stream is ignored
        vec_n = pack4(16'h8000, 16'hFFFF, 16'h0005, 16'h7FFF);
        applyStimulus(1'b0, vec_n);
        for (int i = 0; i < 4; i++) begin
            bus0.in_valid   = (i < 3) ? ((i % 2) == 0) : 1'b0;
            bus0.input_data = pack4(16'(16'h1111 * (i + 1)), 16'(16'h2222 + i),
                                    16'(16'h0F0F ^ i), 16'(16'h1234 + i));
            #1;
            checkOutput("t6.in_ready", 32'(bus0.in_ready), 32'd0);
            checkBeat(1'b0, "t6.beat", 2'(i), vec_n[i], (i == 3));
            tick();
        end
        bus0.in_valid = 1'b0;
        checkIdle(1'b0, "t6.idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
